// File: rtl/calendar_date_counter.sv
// Day/month/two-digit-year register advancing one day per tick, with
// month length supplied by an external days-per-month decoder.
module calendar_date_counter #(
   parameter int unsigned YEAR_MAX    = 99,
   parameter int unsigned RESET_DAY   = 1,
   parameter int unsigned RESET_MONTH = 1,
   parameter int unsigned RESET_YEAR  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       load,
   input  logic [4:0] ld_day,
   input  logic [3:0] ld_month,
   input  logic [6:0] ld_year,
   input  logic       m28,
   input  logic       m29,
   input  logic       m30,
   input  logic       m31,
   output logic [3:0] month,
   output logic       leap,
   output logic [4:0] day,
   output logic [6:0] year,
   output logic       month_end,
   output logic       year_end,
   output logic       load_err,
   output logic       busy
);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CHECK = 1'b1} state_t;

   localparam logic [6:0] YEAR_MAX_C    = 7'(YEAR_MAX);
   localparam logic [4:0] RESET_DAY_C   = 5'(RESET_DAY);
   localparam logic [3:0] RESET_MONTH_C = 4'(RESET_MONTH);
   localparam logic [6:0] RESET_YEAR_C  = 7'(RESET_YEAR);

   state_t     state_r, state_s;
   logic [4:0] day_r, day_s;
   logic [3:0] month_r, month_s;
   logic [6:0] year_r, year_s;
   logic       pend_r, pend_s;
   logic       month_end_r, month_end_s;
   logic       year_end_r, year_end_s;
   logic       load_err_r, load_err_s;
   logic [4:0] len_s;
   logic       len_ok_s;
   logic       ld_bad_s;

   // Decode month length from the decoder's one-hot result.
   always_comb begin
      len_s    = 5'd0;
      len_ok_s = 1'b1;
      if (m31) begin
         len_s = 5'd31;
      end else if (m30) begin
         len_s = 5'd30;
      end else if (m29) begin
         len_s = 5'd29;
      end else if (m28) begin
         len_s = 5'd28;
      end else begin
         len_ok_s = 1'b0;
      end
   end

   assign ld_bad_s = (ld_month == 4'd0) || (ld_month > 4'd12) ||
                     (ld_day == 5'd0) || (ld_year > YEAR_MAX_C);

   // Next-state, date update and pulse generation.
   always_comb begin
      state_s     = state_r;
      day_s       = day_r;
      month_s     = month_r;
      year_s      = year_r;
      pend_s      = pend_r;
      month_end_s = 1'b0;
      year_end_s  = 1'b0;
      load_err_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (load) begin
               // A load supersedes any tick, including one held in pend.
               pend_s = 1'b0;
               if (ld_bad_s) begin
                  load_err_s = 1'b1;
               end else begin
                  day_s   = ld_day;
                  month_s = ld_month;
                  year_s  = ld_year;
                  state_s = ST_CHECK;
               end
            end else if (tick || pend_r) begin
               pend_s = 1'b0;
               if (!len_ok_s) begin
                  day_s = day_r;
               end else if (day_r < len_s) begin
                  day_s = day_r + 5'd1;
               end else if (month_r < 4'd12) begin
                  day_s       = 5'd1;
                  month_s     = month_r + 4'd1;
                  month_end_s = 1'b1;
               end else begin
                  day_s       = 5'd1;
                  month_s     = 4'd1;
                  month_end_s = 1'b1;
                  year_end_s  = 1'b1;
                  year_s      = (year_r == YEAR_MAX_C) ? 7'd0 : year_r + 7'd1;
               end
            end else begin
               pend_s = pend_r;
            end
         end
         ST_CHECK: begin
            // Decoder now sees the loaded month/leap; clamp an over-long day.
            if (len_ok_s && (day_r > len_s)) begin
               day_s      = len_s;
               load_err_s = 1'b1;
            end else begin
               day_s = day_r;
            end
            pend_s  = tick;
            state_s = ST_RUN;
         end
         default: begin
            state_s = ST_RUN;
            pend_s  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RUN;
         day_r       <= RESET_DAY_C;
         month_r     <= RESET_MONTH_C;
         year_r      <= RESET_YEAR_C;
         pend_r      <= 1'b0;
         month_end_r <= 1'b0;
         year_end_r  <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         day_r       <= day_s;
         month_r     <= month_s;
         year_r      <= year_s;
         pend_r      <= pend_s;
         month_end_r <= month_end_s;
         year_end_r  <= year_end_s;
         load_err_r  <= load_err_s;
      end
   end

   assign day       = day_r;
   assign month     = month_r;
   assign year      = year_r;
   assign leap      = (year_r[1:0] == 2'b00);
   assign month_end = month_end_r;
   assign year_end  = year_end_r;
   assign load_err  = load_err_r;
   assign busy      = (state_r == ST_CHECK);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Table-driven bench for calendar_date_counter; a behavioural days-per-month
// decoder closes the loop from month/leap back to m28..m31.
module tb_calendar_date_counter;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       load;
   logic [4:0] ld_day;
   logic [3:0] ld_month;
   logic [6:0] ld_year;
   logic       m28, m29, m30, m31;
   logic [3:0] month;
   logic       leap;
   logic [4:0] day;
   logic [6:0] year;
   logic       month_end, year_end, load_err, busy;

   int n_vec;
   int n_err;

   calendar_date_counter dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
      .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
      .m28(m28), .m29(m29), .m30(m30), .m31(m31),
      .month(month), .leap(leap), .day(day), .year(year),
      .month_end(month_end), .year_end(year_end),
      .load_err(load_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural days-per-month decoder.
   always_comb begin
      m28 = 1'b0; m29 = 1'b0; m30 = 1'b0; m31 = 1'b0;
      case (month)
         4'd2:                      if (leap) m29 = 1'b1; else m28 = 1'b1;
         4'd4, 4'd6, 4'd9, 4'd11:   m30 = 1'b1;
         4'd1, 4'd3, 4'd5, 4'd7,
         4'd8, 4'd10, 4'd12:        m31 = 1'b1;
         default:                   m31 = 1'b0;
      endcase
   end

   typedef struct {
      logic       ld;
      logic       tk;
      logic [4:0] ldd;
      logic [3:0] ldm;
      logic [6:0] ldy;
      logic [4:0] ed;
      logic [3:0] em;
      logic [6:0] ey;
      logic       eme;
      logic       eye;
      logic       ele;
      logic       ebz;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic l, logic t, int d, int m, int y,
                               int xd, int xm, int xy,
                               logic me, logic ye, logic le, logic bz);
      vec_t v;
      v.ld = l; v.tk = t;
      v.ldd = 5'(d); v.ldm = 4'(m); v.ldy = 7'(y);
      v.ed = 5'(xd); v.em = 4'(xm); v.ey = 7'(xy);
      v.eme = me; v.eye = ye; v.ele = le; v.ebz = bz;
      return v;
   endfunction

   task automatic check(string name, logic [4:0] xd, logic [3:0] xm, logic [6:0] xy,
                        logic me, logic ye, logic le, logic bz);
      n_vec++;
      if (day !== xd || month !== xm || year !== xy || month_end !== me ||
          year_end !== ye || load_err !== le || busy !== bz) begin
         n_err++;
         $display("FAIL %s: got d=%0d m=%0d y=%0d me=%b ye=%b le=%b busy=%b, want d=%0d m=%0d y=%0d me=%b ye=%b le=%b busy=%b",
                  name, day, month, year, month_end, year_end, load_err, busy,
                  xd, xm, xy, me, ye, le, bz);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; tick = 1'b0; load = 1'b0;
      ld_day = 5'd0; ld_month = 4'd0; ld_year = 7'd0;
      #12 rst_n = 1'b1;
      check("reset", 5'd1, 4'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;

      // January: 31 ticks roll into February.
      for (int i = 1; i <= 31; i++) begin
         tick = 1'b1;
         step();
         check("jan_tick", (i < 31) ? 5'(i + 1) : 5'd1, (i < 31) ? 4'd1 : 4'd2, 7'd0,
               (i == 31), 1'b0, 1'b0, 1'b0);
      end
      tick = 1'b0;
      step();
      check("jan_end_pulse_drop", 5'd1, 4'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      //             ld    tk    d   m   y    xd  xm  xy   me    ye    le    busy
      vecs.push_back(mk(1'b1, 1'b0, 28, 2,  1,  28, 2,  1,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  28, 2,  1,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   1, 3,  1,  1'b1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 28, 2,  4,  28, 2,  4,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  28, 2,  4,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,  29, 2,  4,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   1, 3,  4,  1'b1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 31, 12, 99, 31, 12, 99, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  31, 12, 99, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   1, 1,  0,  1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,   1, 1,  0,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 31, 4,  5,  31, 4,  5,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  30, 4,  5,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  30, 4,  5,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 15, 13, 5,  30, 4,  5,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 15, 0,  5,  30, 4,  5,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0,  0, 3,  5,  30, 4,  5,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 10, 3, 100, 30, 4,  5,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   1, 5,  5,  1'b1, 1'b0, 1'b0, 1'b0));
      // tick during CHECK is deferred by one cycle
      vecs.push_back(mk(1'b1, 1'b0, 30, 6,  7,  30, 6,  7,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,  30, 6,  7,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,   1, 7,  7,  1'b1, 1'b0, 1'b0, 1'b0));
      // load wins over simultaneous tick
      vecs.push_back(mk(1'b1, 1'b1, 10, 3,  8,  10, 3,  8,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  10, 3,  8,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  10, 3,  8,  1'b0, 1'b0, 1'b0, 1'b0));
      // pending tick merges with a new tick: one day only
      vecs.push_back(mk(1'b1, 1'b0,  5, 5,  5,   5, 5,  5,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   5, 5,  5,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   6, 5,  5,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,   6, 5,  5,  1'b0, 1'b0, 1'b0, 1'b0));
      // plain year increment
      vecs.push_back(mk(1'b1, 1'b0, 31, 12, 10, 31, 12, 10, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,  31, 12, 10, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,   1, 1, 11,  1'b1, 1'b1, 1'b0, 1'b0));
      // Feb 29 in a non-leap year clamps to 28
      vecs.push_back(mk(1'b1, 1'b0, 29, 2,  3,  29, 2,  3,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0,  0, 0,  0,  28, 2,  3,  1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1,  0, 0,  0,   1, 3,  3,  1'b1, 1'b0, 1'b0, 1'b0));

      foreach (vecs[i]) begin
         load = vecs[i].ld; tick = vecs[i].tk;
         ld_day = vecs[i].ldd; ld_month = vecs[i].ldm; ld_year = vecs[i].ldy;
         step();
         check($sformatf("vec%0d", i), vecs[i].ed, vecs[i].em, vecs[i].ey,
               vecs[i].eme, vecs[i].eye, vecs[i].ele, vecs[i].ebz);
      end
      load = 1'b0; tick = 1'b0;

      // Asynchronous reset mid-CHECK with a tick that would have been pended.
      load = 1'b1; ld_day = 5'd30; ld_month = 4'd6; ld_year = 7'd7;
      step();
      check("rst_pre_check", 5'd30, 4'd6, 7'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0; tick = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", 5'd1, 4'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2 tick = 1'b0;
      #1 rst_n = 1'b1;
      step();
      check("rst_pend_lost", 5'd1, 4'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("rst_pend_lost2", 5'd1, 4'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
